// File: rtl/uart_fifo_pkg.sv
// Shared types and constants for the UART/FIFO command path.
package uart_fifo_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 434;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        FIN
    } state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Parity bit is present only when FIFO_BLOCK_TX_PARITY_EN is defined.
module uart_tx_byte
    import uart_fifo_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] tx_byte,
    output logic       ready,
    output logic       txd
);

`ifdef FIFO_BLOCK_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned SH_W  = FRAME_BITS - 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W = 4;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

    logic             active, active_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [IDX_W-1:0] bit_idx, idx_n;
    logic [SH_W-1:0]  shreg, sh_n;
    logic             txd_n, ready_n;

    // ready is registered: it is high for the whole idle period and during the
    // last stop-bit cycle, so a load then starts the next frame with no gap.
    always_comb begin
        active_n = active;
        div_n    = div_cnt;
        idx_n    = bit_idx;
        sh_n     = shreg;
        txd_n    = txd;

        if (active) begin
            if (div_cnt == DIV_LAST) begin
                div_n = '0;
                if (bit_idx == IDX_LAST) begin
                    active_n = 1'b0;
                    txd_n    = 1'b1;
                end else begin
                    idx_n = bit_idx + IDX_W'(1);
                    txd_n = shreg[0];
                    sh_n  = {1'b1, shreg[SH_W-1:1]};
                end
            end else begin
                div_n = div_cnt + DIV_W'(1);
            end
        end

        if (load && ready) begin
            active_n = 1'b1;
            div_n    = '0;
            idx_n    = '0;
            txd_n    = 1'b0;
`ifdef FIFO_BLOCK_TX_PARITY_EN
            sh_n     = {1'b1, even_parity(tx_byte), tx_byte};
`else
            sh_n     = {1'b1, tx_byte};
`endif
        end

        ready_n = !active_n || ((idx_n == IDX_LAST) && (div_n == DIV_LAST));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            txd     <= 1'b1;
            ready   <= 1'b1;
        end else begin
            active  <= active_n;
            div_cnt <= div_n;
            bit_idx <= idx_n;
            shreg   <= sh_n;
            txd     <= txd_n;
            ready   <= ready_n;
        end
    end

endmodule

// File: rtl/fifo_block_tx.sv
// Drains BLOCK_BYTES from the byte FIFO as a cmd02 block: header, data, 8-bit checksum over UART.
// Define FIFO_BLOCK_TX_PARITY_EN to add an even-parity bit to every frame.
module fifo_block_tx
    import uart_fifo_pkg::*;
#(
    parameter int unsigned CLK_DIV     = CLK_DIV_DEFAULT,
    parameter int unsigned BLOCK_BYTES = 512,
    parameter logic [7:0]  HDR_BYTE    = CMD_RD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic [7:0] fifo_data,
    output logic       txd
);

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BLOCK_BYTES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] fetch_cnt, fetch_cnt_n;
    logic [CNT_W-1:0] load_cnt, load_cnt_n;
    logic [7:0]       csum, csum_n;
    logic [7:0]       hold_data, hold_data_n;
    logic             hold_full, hold_full_n;
    logic             rd_valid;
    logic             busy_n, done_n, fifo_rd_n;
    logic             load_c;
    logic [7:0]       tx_byte_c;
    logic             tx_ready;

    always_comb begin
        state_n     = state;
        fetch_cnt_n = fetch_cnt;
        load_cnt_n  = load_cnt;
        csum_n      = csum;
        hold_data_n = hold_data;
        hold_full_n = hold_full;
        busy_n      = busy;
        done_n      = 1'b0;
        fifo_rd_n   = 1'b0;
        load_c      = 1'b0;
        tx_byte_c   = HDR_BYTE;

        // Registered FIFO read: data arrives the cycle after the strobe.
        if (rd_valid) begin
            hold_data_n = fifo_data;
            hold_full_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = HDR;
                    busy_n      = 1'b1;
                    fetch_cnt_n = '0;
                    load_cnt_n  = '0;
                    csum_n      = '0;
                    hold_full_n = 1'b0;
                end
            end
            HDR: begin
                if (tx_ready) begin
                    load_c    = 1'b1;
                    tx_byte_c = HDR_BYTE;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (tx_ready && hold_full) begin
                    load_c      = 1'b1;
                    tx_byte_c   = hold_data;
                    csum_n      = csum + hold_data;
                    hold_full_n = 1'b0;
                    load_cnt_n  = load_cnt + CNT_W'(1);
                    if (load_cnt == LAST_IDX) begin
                        state_n = CSUM;
                    end
                end
            end
            CSUM: begin
                if (tx_ready) begin
                    load_c    = 1'b1;
                    tx_byte_c = csum;
                    state_n   = FIN;
                end
            end
            FIN: begin
                if (tx_ready) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // One read in flight at most; the fetch count caps reads at BLOCK_BYTES.
        if (((state_n == HDR) || (state_n == DATA)) && !hold_full_n && !fifo_rd && !rd_valid
            && !fifo_empty && (fetch_cnt_n < BLOCK_CNT)) begin
            fifo_rd_n   = 1'b1;
            fetch_cnt_n = fetch_cnt_n + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fetch_cnt <= '0;
            load_cnt  <= '0;
            csum      <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fifo_rd   <= 1'b0;
        end else begin
            state     <= state_n;
            fetch_cnt <= fetch_cnt_n;
            load_cnt  <= load_cnt_n;
            csum      <= csum_n;
            hold_data <= hold_data_n;
            hold_full <= hold_full_n;
            rd_valid  <= fifo_rd;
            busy      <= busy_n;
            done      <= done_n;
            fifo_rd   <= fifo_rd_n;
        end
    end

    uart_tx_byte #(
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .load   (load_c),
        .tx_byte(tx_byte_c),
        .ready  (tx_ready),
        .txd    (txd)
    );

endmodule
